// File: rtl/block_mover.sv
// Keyboard-steered square object for one on-screen sprite.
// A key press and any edge response to it are applied in the same frame.
module block_mover #(
    parameter int          W        = 10,
    parameter int          X_MIN    = 100,
    parameter int          X_MAX    = 500,
    parameter int          Y_MIN    = 50,
    parameter int          Y_MAX    = 430,
    parameter int          X_CENTER = 320,
    parameter int          Y_CENTER = 240,
    parameter int          SIZE     = 8,
    parameter int          STEP     = 2,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_RIGHT = 8'h07,
    parameter logic [7:0]  KEY_DOWN  = 8'h16,
    parameter logic [7:0]  KEY_UP    = 8'h1A
) (
    input  logic         frame_clk,
    input  logic         Reset_n,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic [7:0]   keycode,
    output logic [W-1:0] BlockX,
    output logic [W-1:0] BlockY,
    output logic [W-1:0] BlockS,
    output logic [1:0]   dir,
    output logic         moving,
    output logic         edge_hit
);

    typedef enum logic {S_IDLE = 1'b0, S_MOVE = 1'b1} state_t;

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_STOP   = 2'b01;
    localparam logic [1:0] MODE_WRAP   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    // Centre-position limits: the block edge stays inside [MIN, MAX].
    localparam logic [W:0] X_LO   = (W+1)'(X_MIN + SIZE);
    localparam logic [W:0] X_HI   = (W+1)'(X_MAX - SIZE);
    localparam logic [W:0] Y_LO   = (W+1)'(Y_MIN + SIZE);
    localparam logic [W:0] Y_HI   = (W+1)'(Y_MAX - SIZE);
    localparam logic [W:0] STEP_P = (W+1)'(STEP);
    localparam logic [W:0] STEP_N = (W+1)'(-STEP);
    localparam logic [W:0] ZERO   = {(W+1){1'b0}};

    state_t       state_q, state_d;
    logic [1:0]   dir_q, dir_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic [W:0]   mx_q, mx_d, my_q, my_d;   // two's-complement motion per axis
    logic         hit_q, hit_d;

    state_t       key_state_s;
    logic [1:0]   key_dir_s;
    logic [W:0]   key_mx_s, key_my_s;
    logic [W:0]   nx_s, ny_s;
    logic         x_hi_s, x_lo_s, y_hi_s, y_lo_s, viol_s;
    logic [W-1:0] x_clamp_s, x_wrap_s, y_clamp_s, y_wrap_s;

    // Key decode: a bound key replaces direction and motion, anything else keeps them.
    always_comb begin
        key_state_s = state_q;
        key_dir_s   = dir_q;
        key_mx_s    = mx_q;
        key_my_s    = my_q;
        case (keycode)
            KEY_LEFT: begin
                key_state_s = S_MOVE; key_dir_s = DIR_LEFT;  key_mx_s = STEP_N; key_my_s = ZERO;
            end
            KEY_RIGHT: begin
                key_state_s = S_MOVE; key_dir_s = DIR_RIGHT; key_mx_s = STEP_P; key_my_s = ZERO;
            end
            KEY_DOWN: begin
                key_state_s = S_MOVE; key_dir_s = DIR_DOWN;  key_mx_s = ZERO;   key_my_s = STEP_P;
            end
            KEY_UP: begin
                key_state_s = S_MOVE; key_dir_s = DIR_UP;    key_mx_s = ZERO;   key_my_s = STEP_N;
            end
            default: begin
                key_state_s = state_q;
            end
        endcase
    end

    // Position never drops below STEP, so the W+1 bit sum cannot go negative.
    assign nx_s   = {1'b0, x_q} + key_mx_s;
    assign ny_s   = {1'b0, y_q} + key_my_s;
    assign x_hi_s = (nx_s > X_HI);
    assign x_lo_s = (nx_s < X_LO);
    assign y_hi_s = (ny_s > Y_HI);
    assign y_lo_s = (ny_s < Y_LO);
    assign viol_s = x_hi_s | x_lo_s | y_hi_s | y_lo_s;

    // Per-axis clamp and wrap targets for the candidate position.
    always_comb begin
        x_clamp_s = nx_s[W-1:0];
        x_wrap_s  = nx_s[W-1:0];
        y_clamp_s = ny_s[W-1:0];
        y_wrap_s  = ny_s[W-1:0];
        if (x_hi_s) begin
            x_clamp_s = X_HI[W-1:0];
            x_wrap_s  = X_LO[W-1:0];
        end else if (x_lo_s) begin
            x_clamp_s = X_LO[W-1:0];
            x_wrap_s  = X_HI[W-1:0];
        end else begin
            x_clamp_s = nx_s[W-1:0];
        end
        if (y_hi_s) begin
            y_clamp_s = Y_HI[W-1:0];
            y_wrap_s  = Y_LO[W-1:0];
        end else if (y_lo_s) begin
            y_clamp_s = Y_LO[W-1:0];
            y_wrap_s  = Y_HI[W-1:0];
        end else begin
            y_clamp_s = ny_s[W-1:0];
        end
    end

    // Next-state: key result first, then edge handling by mode.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        mx_d    = mx_q;
        my_d    = my_q;
        hit_d   = 1'b0;
        if (enable) begin
            state_d = key_state_s;
            dir_d   = key_dir_s;
            mx_d    = key_mx_s;
            my_d    = key_my_s;
            if (mode == MODE_FREEZE) begin
                hit_d = 1'b0;
            end else if (viol_s) begin
                hit_d = 1'b1;
                case (mode)
                    MODE_BOUNCE: begin
                        x_d   = x_clamp_s;
                        y_d   = y_clamp_s;
                        mx_d  = -key_mx_s;
                        my_d  = -key_my_s;
                        dir_d = key_dir_s ^ 2'b01;
                    end
                    MODE_STOP: begin
                        x_d     = x_clamp_s;
                        y_d     = y_clamp_s;
                        mx_d    = ZERO;
                        my_d    = ZERO;
                        state_d = S_IDLE;
                    end
                    MODE_WRAP: begin
                        x_d = x_wrap_s;
                        y_d = y_wrap_s;
                    end
                    default: begin
                        hit_d = 1'b0;
                    end
                endcase
            end else begin
                x_d = nx_s[W-1:0];
                y_d = ny_s[W-1:0];
            end
        end else begin
            hit_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_RIGHT;
            x_q     <= W'(X_CENTER);
            y_q     <= W'(Y_CENTER);
            mx_q    <= ZERO;
            my_q    <= ZERO;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            hit_q   <= hit_d;
        end
    end

    assign BlockX   = x_q;
    assign BlockY   = y_q;
    assign BlockS   = W'(SIZE);
    assign dir      = dir_q;
    assign moving   = (state_q == S_MOVE);
    assign edge_hit = hit_q;

endmodule

// File: tb/tb_block_mover.sv
// Randomised self-checking bench for block_mover against a frame-level
// integer model of position, motion, direction and edge response.
module tb_block_mover;

    localparam int W = 10, X_MIN = 100, X_MAX = 500, Y_MIN = 50, Y_MAX = 430;
    localparam int XC = 320, YC = 240, SIZE = 8, STEP = 2;

    logic         frame_clk, Reset_n, enable;
    logic [1:0]   mode;
    logic [7:0]   keycode;
    logic [W-1:0] BlockX, BlockY, BlockS;
    logic [1:0]   dir;
    logic         moving, edge_hit;

    int checks = 0;
    int errors = 0;

    int m_x, m_y, m_dx, m_dy, m_dir;
    bit m_mov, m_hit;

    block_mover dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .enable(enable), .mode(mode),
        .keycode(keycode), .BlockX(BlockX), .BlockY(BlockY), .BlockS(BlockS),
        .dir(dir), .moving(moving), .edge_hit(edge_hit)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    function automatic int clamp_to(int v, int lo, int hi);
        if (v + SIZE > hi) return hi - SIZE;
        if (v - SIZE < lo) return lo + SIZE;
        return v;
    endfunction

    function automatic int wrap_to(int v, int lo, int hi);
        if (v + SIZE > hi) return lo + SIZE;
        if (v - SIZE < lo) return hi - SIZE;
        return v;
    endfunction

    task automatic model_reset();
        m_x = XC; m_y = YC; m_dx = 0; m_dy = 0; m_dir = 0; m_mov = 1'b0; m_hit = 1'b0;
    endtask

    task automatic model_step();
        int nx, ny;
        if (!enable) begin
            m_hit = 1'b0;
            return;
        end
        case (keycode)
            8'h04: begin m_dx = -STEP; m_dy = 0;     m_dir = 1; m_mov = 1'b1; end
            8'h07: begin m_dx = STEP;  m_dy = 0;     m_dir = 0; m_mov = 1'b1; end
            8'h16: begin m_dx = 0;     m_dy = STEP;  m_dir = 2; m_mov = 1'b1; end
            8'h1A: begin m_dx = 0;     m_dy = -STEP; m_dir = 3; m_mov = 1'b1; end
            default: ;
        endcase
        if (mode == 2'b11) begin
            m_hit = 1'b0;
            return;
        end
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        m_hit = (nx + SIZE > X_MAX) || (nx - SIZE < X_MIN) ||
                (ny + SIZE > Y_MAX) || (ny - SIZE < Y_MIN);
        if (!m_hit) begin
            m_x = nx; m_y = ny;
        end else if (mode == 2'b00) begin
            m_x = clamp_to(nx, X_MIN, X_MAX); m_y = clamp_to(ny, Y_MIN, Y_MAX);
            m_dx = -m_dx; m_dy = -m_dy; m_dir = m_dir ^ 1;
        end else if (mode == 2'b01) begin
            m_x = clamp_to(nx, X_MIN, X_MAX); m_y = clamp_to(ny, Y_MIN, Y_MAX);
            m_dx = 0; m_dy = 0; m_mov = 1'b0;
        end else begin
            m_x = wrap_to(nx, X_MIN, X_MAX); m_y = wrap_to(ny, Y_MIN, Y_MAX);
        end
    endtask

    function automatic logic [2*W+3:0] exp_vec();
        return {W'(m_x), W'(m_y), 2'(m_dir), m_mov, m_hit};
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; enable = 1'b1; mode = 2'b00; keycode = 8'h00;
        model_reset();
        #12 Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL reset frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
        end
        checks++;
        if (BlockS !== W'(SIZE)) begin
            errors++;
            $display("FAIL block_size: got %0d, expected %0d", BlockS, SIZE);
        end
    endtask

    task automatic test_key_step();
        keycode = 8'h07;
        for (int i = 0; i < 3; i++) begin
            tick();
            keycode = 8'h00;
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL key_step frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
            checks++;
            if (BlockX !== W'(XC + STEP * (i + 1))) begin
                errors++;
                $display("FAIL same_frame_step %0d: got x=%0d, expected %0d", i, BlockX, XC + STEP * (i + 1));
            end
        end
    endtask

    task automatic test_bounce();
        bit seen = 1'b0;
        mode = 2'b00; keycode = 8'h00;
        for (int i = 0; i < 150; i++) begin
            tick();
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL bounce frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
            if (m_hit && !seen) begin
                seen = 1'b1;
                checks++;
                if (BlockX !== W'(X_MAX - SIZE) || dir !== 2'b01 || edge_hit !== 1'b1) begin
                    errors++;
                    $display("FAIL bounce_clamp: got x=%0d dir=%0d hit=%0d, expected x=%0d dir=1 hit=1",
                             BlockX, dir, edge_hit, X_MAX - SIZE);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bounce_reached: got no edge hit within 150 frames, expected one");
        end
        keycode = 8'h07;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL bounce_pinned frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
        end
        checks++;
        if (BlockX !== W'(X_MAX - SIZE) || edge_hit !== 1'b1 || moving !== 1'b1) begin
            errors++;
            $display("FAIL bounce_pinned_end: got x=%0d hit=%0d mv=%0d, expected x=%0d hit=1 mv=1",
                     BlockX, edge_hit, moving, X_MAX - SIZE);
        end
    endtask

    task automatic test_stop();
        mode = 2'b01; keycode = 8'h1A;
        for (int i = 0; i < 120; i++) begin
            tick();
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL stop frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
        end
        checks++;
        if (BlockY !== W'(Y_MIN + SIZE) || moving !== 1'b0 || edge_hit !== 1'b1) begin
            errors++;
            $display("FAIL stop_pinned: got y=%0d mv=%0d hit=%0d, expected y=%0d mv=0 hit=1",
                     BlockY, moving, edge_hit, Y_MIN + SIZE);
        end
    endtask

    task automatic test_wrap();
        bit seen = 1'b0;
        mode = 2'b10; keycode = 8'h04;
        for (int i = 0; i < 300; i++) begin
            tick();
            keycode = 8'h00;
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL wrap frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
            if (m_hit && !seen) begin
                seen = 1'b1;
                checks++;
                if (BlockX !== W'(X_MAX - SIZE) || edge_hit !== 1'b1 || dir !== 2'b01) begin
                    errors++;
                    $display("FAIL wrap_jump: got x=%0d hit=%0d dir=%0d, expected x=%0d hit=1 dir=1",
                             BlockX, edge_hit, dir, X_MAX - SIZE);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wrap_reached: got no wrap within 300 frames, expected one");
        end
    endtask

    task automatic test_hold_and_reset();
        int x0, y0;
        x0 = m_x; y0 = m_y;
        mode = 2'b11; keycode = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (BlockX !== W'(x0) || BlockY !== W'(y0) || edge_hit !== 1'b0 || moving !== 1'b1) begin
                errors++;
                $display("FAIL freeze frame %0d: got x=%0d y=%0d hit=%0d mv=%0d, expected x=%0d y=%0d hit=0 mv=1",
                         i, BlockX, BlockY, edge_hit, moving, x0, y0);
            end
        end
        enable = 1'b0; keycode = 8'h16;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec() || dir !== 2'b01) begin
                errors++;
                $display("FAIL disabled frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=1 mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_mov, m_hit);
            end
        end
        @(posedge frame_clk);
        #3 Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (BlockX !== W'(XC) || BlockY !== W'(YC) || moving !== 1'b0 || edge_hit !== 1'b0 || dir !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got x=%0d y=%0d mv=%0d hit=%0d dir=%0d, expected x=%0d y=%0d mv=0 hit=0 dir=0",
                     BlockX, BlockY, moving, edge_hit, dir, XC, YC);
        end
        #2 Reset_n = 1'b1;
        enable = 1'b1; keycode = 8'h00; mode = 2'b00;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 11))
                0: keycode = 8'h04;
                1: keycode = 8'h07;
                2: keycode = 8'h16;
                3: keycode = 8'h1A;
                4: keycode = 8'($urandom);
                default: keycode = 8'h00;
            endcase
            tick();
            checks++;
            if ({BlockX, BlockY, dir, moving, edge_hit} !== exp_vec()) begin
                errors++;
                $display("FAIL random frame %0d: got x=%0d y=%0d dir=%0d mv=%0d hit=%0d, expected x=%0d y=%0d dir=%0d mv=%0d hit=%0d",
                         i, BlockX, BlockY, dir, moving, edge_hit, m_x, m_y, m_dir, m_mov, m_hit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_key_step();
        test_bounce();
        test_stop();
        test_wrap();
        test_hold_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
